// File: rtl/pfs_dc_pkg.sv
// Shared tag encodings and unpacker state type for the daughtercard FIFO read path.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pfs_dc_pkg;

    localparam int TAG_MSB = 33;

    localparam logic [1:0] TAG_MID = 2'b00;
    localparam logic [1:0] TAG_SOF = 2'b01;
    localparam logic [1:0] TAG_EOF = 2'b10;
    localparam logic [1:0] TAG_ONE = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_FRAME = 2'd1,
        DISCARD  = 2'd2
    } dc_unpack_state_t;

endpackage

// File: rtl/dc_word_shifter.sv
// Holds one 32-bit payload and serializes it MSB byte first with SOF/EOF qualifiers.
// Latency: byte 0 valid the cycle after load_i; one byte per accepted cycle.
// Backpressure: outputs frozen while byte_valid_o & !byte_ready_i; reload allowed on last-byte accept.
module dc_word_shifter (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        load_sof_i,
    input  logic        load_eof_i,
    input  logic        load_cnt_i,
    input  logic        byte_ready_i,
    output logic [7:0]  byte_data_o,
    output logic        byte_valid_o,
    output logic        byte_sof_o,
    output logic        byte_eof_o,
    output logic        hold_empty_o,
    output logic        last_byte_accepted_o,
    output logic        frame_done_o
);

    logic [31:0] word_q;
    logic [1:0]  idx_q;
    logic        vld_q;
    logic        sof_q;
    logic        eof_q;
    logic        cnt_q;
    logic        accept;

    assign accept = vld_q & byte_ready_i;

    // Select the current byte, most significant first.
    always_comb begin
        byte_data_o = word_q[31:24];
        case (idx_q)
            2'd0:    byte_data_o = word_q[31:24];
            2'd1:    byte_data_o = word_q[23:16];
            2'd2:    byte_data_o = word_q[15:8];
            default: byte_data_o = word_q[7:0];
        endcase
    end

    assign byte_valid_o         = vld_q;
    assign byte_sof_o           = vld_q & sof_q & (idx_q == 2'd0);
    assign byte_eof_o           = vld_q & eof_q & (idx_q == 2'd3);
    assign hold_empty_o         = ~vld_q;
    assign last_byte_accepted_o = accept & (idx_q == 2'd3);
    // cnt_q marks a word whose last byte completes a good frame.
    assign frame_done_o         = accept & (idx_q == 2'd3) & cnt_q;

    // Load a new word (wins over advance so a last-byte accept reloads without a bubble), else step on accept.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_q <= '0;
            idx_q  <= 2'd0;
            vld_q  <= 1'b0;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            cnt_q  <= 1'b0;
        end else if (load_i) begin
            word_q <= load_data_i;
            idx_q  <= 2'd0;
            vld_q  <= 1'b1;
            sof_q  <= load_sof_i;
            eof_q  <= load_eof_i;
            cnt_q  <= load_cnt_i;
        end else if (accept) begin
            if (idx_q == 2'd3) begin
                vld_q <= 1'b0;
            end
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/dc_fifo_unpacker.sv
// Pops tagged 34-bit FWFT FIFO words, checks framing, emits payload bytes with SOF/EOF.
// Latency: 1 cycle from FIFO non-empty to first byte_valid; sustains 1 byte/cycle.
// Backpressure: byte_ready low stalls the byte stream; pops stop until the held word drains.
module dc_fifo_unpacker
    import pfs_dc_pkg::*;
#(
    parameter int DWIDTH    = 34,
    parameter int MAX_WORDS = 256,
    parameter int CNT_W     = 16
) (
    input  logic              rd_clk,
    input  logic              reset,
    input  logic [DWIDTH-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_sof,
    output logic              byte_eof,
    output logic              frame_err,
    output logic [CNT_W-1:0]  frame_count,
    output logic              busy
);

    localparam int                WCNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [WCNT_W-1:0] WMAX   = WCNT_W'(MAX_WORDS);
    localparam logic [WCNT_W-1:0] WONE   = WCNT_W'(1);

    dc_unpack_state_t  state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
    logic [CNT_W-1:0]  frame_count_q;
    logic [1:0]        tag;
    logic              hold_empty, last_byte_accepted, frame_done, discard_pop;
    logic              load, ld_sof, ld_eof, ld_cnt, err;

    assign tag         = fifo_dout[TAG_MSB:TAG_MSB-1];
    // A SOF seen while discarding starts a new frame, so it must wait for the holding register.
    assign discard_pop = (state_q == DISCARD) && (tag != TAG_SOF);
    assign fifo_rd_en  = !reset && !fifo_empty && (hold_empty || last_byte_accepted || discard_pop);
    assign wcnt_inc    = (wcnt_q == WMAX) ? WMAX : wcnt_q + 1'b1;

    // Decide what to do with the word being popped this cycle.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        load    = 1'b0;
        ld_sof  = 1'b0;
        ld_eof  = 1'b0;
        ld_cnt  = 1'b0;
        err     = 1'b0;
        if (fifo_rd_en) begin
            if (state_q == DISCARD) begin
                if (tag == TAG_SOF) begin
                    load    = 1'b1;
                    ld_sof  = 1'b1;
                    state_d = IN_FRAME;
                    wcnt_d  = WONE;
                end else if (tag == TAG_EOF || tag == TAG_ONE) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end
            end else if (state_q == IN_FRAME && tag == TAG_MID) begin
                load   = 1'b1;
                wcnt_d = wcnt_inc;
                // Frame hit its word limit: close it early and drop the rest.
                if (wcnt_inc == WMAX) begin
                    ld_eof  = 1'b1;
                    err     = 1'b1;
                    state_d = DISCARD;
                end
            end else if (state_q == IN_FRAME && tag == TAG_EOF) begin
                load    = 1'b1;
                ld_eof  = 1'b1;
                ld_cnt  = 1'b1;
                state_d = IDLE;
                wcnt_d  = '0;
            end else begin
                // IDLE handling; a SOF/ONE inside a frame abandons that frame.
                err = (state_q == IN_FRAME);
                case (tag)
                    TAG_SOF: begin
                        load    = 1'b1;
                        ld_sof  = 1'b1;
                        state_d = IN_FRAME;
                        wcnt_d  = WONE;
                    end
                    TAG_ONE: begin
                        load    = 1'b1;
                        ld_sof  = 1'b1;
                        ld_eof  = 1'b1;
                        ld_cnt  = 1'b1;
                        state_d = IDLE;
                        wcnt_d  = '0;
                    end
                    default: begin
                        err     = 1'b1;
                        state_d = IDLE;
                        wcnt_d  = '0;
                    end
                endcase
            end
        end
    end

    // State, word counter and good-frame counter.
    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            wcnt_q        <= '0;
            frame_count_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (frame_done) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    dc_word_shifter u_shifter (
        .clk_i                (rd_clk),
        .reset_i              (reset),
        .load_i               (load),
        .load_data_i          (fifo_dout[31:0]),
        .load_sof_i           (ld_sof),
        .load_eof_i           (ld_eof),
        .load_cnt_i           (ld_cnt),
        .byte_ready_i         (byte_ready),
        .byte_data_o          (byte_data),
        .byte_valid_o         (byte_valid),
        .byte_sof_o           (byte_sof),
        .byte_eof_o           (byte_eof),
        .hold_empty_o         (hold_empty),
        .last_byte_accepted_o (last_byte_accepted),
        .frame_done_o         (frame_done)
    );

    assign frame_err   = err;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != IDLE) || !hold_empty;

endmodule
